// File: rtl/byte_serial_pkg.sv
// Shared definitions for the byte-serial adder: FSM state encoding and byte width.
package byte_serial_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/byte_serial_adder_cla8.sv
// 8-bit carry-look-ahead adder; every carry is a flat sum of products of
// generate/propagate terms, so no carry ripples through earlier bit positions.
module byte_serial_adder_cla8
    import byte_serial_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic              cout,
    output logic [BYTE_W-1:0] sum
);

    logic [BYTE_W-1:0] gen;
    logic [BYTE_W-1:0] prop;
    logic [BYTE_W:0]   carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    // carry[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
    always_comb begin
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < BYTE_W; i++) begin
            logic term_chain;
            logic c_acc;
            c_acc      = gen[i];
            term_chain = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                c_acc      = c_acc | (term_chain & gen[j]);
                term_chain = term_chain & prop[j];
            end
            carry[i+1] = c_acc | (term_chain & cin);
        end
    end

    assign sum  = prop ^ carry[BYTE_W-1:0];
    assign cout = carry[BYTE_W];

endmodule

// File: rtl/byte_serial_adder.sv
// Multi-byte adder that processes one byte per cycle through a single 8-bit CLA.
// Define OVERFLOW_FLAG_EN to add the signed-overflow output ovf.
module byte_serial_adder
    import byte_serial_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] sum,
    output logic                     cout
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic                     ovf
`endif
);

    localparam int W = BYTE_W * NBYTES;

    state_t            state;
    state_t            state_next;
    logic [2:0]        idx;
    logic [W-1:0]      a_reg;
    logic [W-1:0]      b_reg;
    logic              carry;
    logic [BYTE_W-1:0] byte_a;
    logic [BYTE_W-1:0] byte_b;
    logic [BYTE_W-1:0] byte_sum;
    logic              byte_cout;
    logic              last_byte;
    logic              accept;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_ready && in_valid;
    assign last_byte = (idx == 3'(NBYTES - 1));
    assign byte_a    = a_reg[{idx, 3'b000} +: BYTE_W];
    assign byte_b    = b_reg[{idx, 3'b000} +: BYTE_W];
    assign cout      = carry;

    byte_serial_adder_cla8 u_cla (
        .a    (byte_a),
        .b    (byte_b),
        .cin  (carry),
        .cout (byte_cout),
        .sum  (byte_sum)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_byte) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The carry register doubles as cout: after the last byte it holds the final carry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            sum   <= '0;
        end else if (accept) begin
            idx   <= '0;
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            sum   <= '0;
        end else if (state == RUN) begin
            sum[{idx, 3'b000} +: BYTE_W] <= byte_sum;
            carry <= byte_cout;
            idx   <= idx + 3'd1;
        end
    end

`ifdef OVERFLOW_FLAG_EN
    // Signed overflow: operand signs agree but the result sign differs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (state == RUN && last_byte) begin
            ovf <= (a_reg[W-1] == b_reg[W-1]) && (byte_sum[BYTE_W-1] != a_reg[W-1]);
        end
    end
`endif

endmodule
